motor_step_gen: RTL and testbench
=================================

// Module: motor_step_gen
// PURPOSE
//  Transmit side of the motor pulse interface: turns a step command (count, period, direction)
//  into a train of clean fixed-width step pulses plus a direction level.
//  Drives the motor driver or a loop-back edge detector; each step produces one rising
//  and one falling edge on `step`. Sits between the controller command register and the
//  motor driver pins.
// PARAMETERS
//  CNT_W      16  width of step count / steps_left
//  PER_W      16  width of period field (clock cycles, rising-to-rising step edge)
//  PULSE_W    4   step high time in cycles (>=1)
//  DIR_SETUP  2   cycles from command accept to first step rise (>=1); dir valid throughout
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst         in   1      asynchronous, active-low reset
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      block can accept command (high only in IDLE)
//  cmd_dir     in   1      direction for this command (1 = forward)
//  cmd_steps   in   CNT_W  number of steps to emit
//  cmd_period  in   PER_W  step period in cycles
//  abort       in   1      stop current command at next safe point
//  step        out  1      step pulse, registered, glitch-free
//  dir         out  1      direction level, registered
//  busy        out  1      high from accept until done
//  done        out  1      one-cycle pulse when command finishes or aborts
//  steps_left  out  CNT_W  steps still to be started
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; step=0, dir=0, busy=0, done=0, steps_left=0, cmd_ready=1.
//  - Accept on rising edge with cmd_valid && cmd_ready; latch dir, steps, P_eff;
//    dir output updates on that edge.
//  - P_eff = max(cmd_period, PULSE_W+1); period is never shorter than pulse + 1 low cycle.
//  - FSM states: IDLE, SETUP, HIGH, LOW.
//    - IDLE --accept, steps>0--> SETUP
//    - IDLE --accept, steps==0--> IDLE with done=1 in the next cycle; no pulse, busy stays 0.
//    - SETUP: held DIR_SETUP-1 cycles, then HIGH. The first step rise is registered on
//      edge DIR_SETUP after the accept edge.
//    - HIGH: step=1 for exactly PULSE_W cycles; steps_left decrements on the entry edge.
//    - LOW: step=0 for P_eff-PULSE_W cycles, then HIGH if steps_left>0, else IDLE with done=1.
//  - Total command time = DIR_SETUP + steps*P_eff cycles, measured from the accept edge to
//    the edge that raises done.
//  - cmd_ready = (state==IDLE). A command may be accepted in the same cycle done is high.
//    cmd_valid while busy is ignored and not queued.
//  - busy=1 from the accept edge until the edge that raises done.
//  - abort (sampled each edge):
//    - IDLE: ignored.
//    - SETUP or LOW: next state IDLE, done=1, step stays 0.
//    - HIGH: the current pulse completes its full PULSE_W width (no runt pulse), then
//      IDLE + done.
//    - abort coincident with the final LOW cycle: a single done pulse only.
//  - dir never changes while busy.
//  - Counters: period timer is PER_W bits and loads, never free-runs or wraps; steps_left
//    saturates at 0.
//  - Reset mid-pulse forces step=0 immediately (async). No partial pulse resumes after release.
// STRUCTURE
//  - motor_pkg: typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} step_state_t;
//    localparam defaults for CNT_W / PER_W shared with the pulse receiver.
//  - Sub-module motor_step_timer: loadable PER_W down-counter with zero flag,
//    used for the SETUP/HIGH/LOW phase timing.
//  - Top: FSM, step count register, registered outputs.
// TESTING
//  1. Reset: rst=0 mid-run with step=1 -> step, dir, busy, done, steps_left all 0 at
//     once; cmd_ready=1 after release.
//  2. steps=3, period=10, dir=1 (PULSE_W=4, DIR_SETUP=2):
//     - step rises at edges 2, 12, 22 after accept; each pulse is 4 cycles high.
//     - done at edge 32; steps_left 3->2->1->0; dir=1 throughout.
//  3. steps=0 -> no step edge, busy stays 0, done pulse next cycle, cmd_ready stays 1.
//  4. period=2 (< PULSE_W+1) with steps=2 -> P_eff=5; rises 5 cycles apart, 1 low cycle
//     between pulses.
//  5. abort one cycle into the 2nd HIGH of a 5-step command:
//     - pulse still 4 cycles wide, then done; 2 rises total, steps_left=3.
//  6. New cmd_valid while busy ignored; back-to-back accept in the done cycle with
//     dir=0 -> dir flips on that edge, next rise DIR_SETUP later.
//     Loop step to an edge detector -> exactly 2 change pulses per step.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and default widths for the motor pulse interface (step generator and receiver).
package motor_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} step_state_t;

    localparam int unsigned MOTOR_CNT_W = 16;
    localparam int unsigned MOTOR_PER_W = 16;

endpackage

// File: rtl/motor_step_timer.sv
// Loadable down-counter that times the SETUP/HIGH/LOW phases; holds at zero, never wraps.
module motor_step_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/motor_step_gen.sv
// Step pulse generator: turns a (steps, period, dir) command into fixed-width step pulses.
module motor_step_gen
    import motor_pkg::*;
#(
    parameter int unsigned CNT_W     = MOTOR_CNT_W,
    parameter int unsigned PER_W     = MOTOR_PER_W,
    parameter int unsigned PULSE_W   = 4,
    parameter int unsigned DIR_SETUP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    step_state_t      state_q, state_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             done_q, done_d;
    logic             abort_pend_q, abort_pend_d;

    logic             tmr_load;
    logic [PER_W-1:0] tmr_val;
    logic             tmr_zero;
    logic [PER_W-1:0] p_eff;

    // Period is stretched so every pulse is followed by at least one low cycle.
    assign p_eff = (cmd_period < PER_W'(PULSE_W + 1)) ? PER_W'(PULSE_W + 1) : cmd_period;

    motor_step_timer #(
        .W (PER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        steps_d      = steps_q;
        period_d     = period_q;
        dir_d        = dir_q;
        done_d       = 1'b0;
        abort_pend_d = abort_pend_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        case (state_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                if (cmd_valid) begin
                    dir_d    = cmd_dir;
                    period_d = p_eff;
                    steps_d  = cmd_steps;
                    if (cmd_steps != '0) begin
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = PER_W'(DIR_SETUP - 1);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tmr_zero) begin
                    state_d  = HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = PER_W'(PULSE_W - 1);
                    if (steps_q != '0) steps_d = steps_q - CNT_W'(1);
                end
            end
            HIGH: begin
                // An abort during the pulse is remembered so the pulse keeps its full width.
                if (abort) abort_pend_d = 1'b1;
                if (tmr_zero) begin
                    if (abort || abort_pend_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = LOW;
                        tmr_load = 1'b1;
                        tmr_val  = period_q - PER_W'(PULSE_W) - PER_W'(1);
                    end
                end
            end
            LOW: begin
                if (abort || (tmr_zero && steps_q == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tmr_zero) begin
                    state_d  = HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = PER_W'(PULSE_W - 1);
                    steps_d  = steps_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        step_d = (state_d == HIGH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            steps_q      <= '0;
            period_q     <= '0;
            dir_q        <= 1'b0;
            step_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            steps_q      <= steps_d;
            period_q     <= period_d;
            dir_q        <= dir_d;
            step_q       <= step_d;
            done_q       <= done_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign step       = step_q;
    assign dir        = dir_q;
    assign done       = done_q;
    assign steps_left = steps_q;

endmodule

// File: tb/tb_motor_step_gen.sv
// Self-checking bench for motor_step_gen: directed table, hand sequences, randomized commands.
module tb_motor_step_gen;

    localparam int DS = 2;
    localparam int PW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic [15:0] cmd_period;
    logic        abort;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic [15:0] steps_left;

    int n_tests = 0;
    int n_fail  = 0;

    motor_step_gen #(
        .CNT_W     (16),
        .PER_W     (16),
        .PULSE_W   (PW),
        .DIR_SETUP (DS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: step timing derived from rise times DS + k*P_eff.
    int m_steps, m_p, m_end, m_nr;

    function automatic int peff(input int p);
        return (p < PW + 1) ? PW + 1 : p;
    endfunction

    function automatic int m_step(input int t);
        int k;
        if (m_steps == 0 || t < DS) return 0;
        k = (t - DS) / m_p;
        if (k >= m_steps || k >= m_nr) return 0;
        return ((t - DS) % m_p < PW) ? 1 : 0;
    endfunction

    function automatic int m_left(input int t);
        int r;
        if (m_steps == 0) return 0;
        r = (t < DS) ? 0 : (t - DS) / m_p + 1;
        if (r > m_nr) r = m_nr;
        return m_steps - r;
    endfunction

    task automatic model_setup(input int steps, input int period, input int abort_at);
        int k;
        m_steps = steps;
        m_p     = peff(period);
        m_end   = (steps == 0) ? 0 : DS + steps * m_p;
        m_nr    = steps;
        if (steps > 0 && abort_at > 0 && abort_at <= m_end) begin
            if (m_step(abort_at - 1) == 1) begin
                k     = (abort_at - 1 - DS) / m_p;
                m_end = DS + k * m_p + PW;
            end else begin
                m_end = abort_at;
            end
        end
        m_nr = (m_end > DS) ? ((m_end - DS + m_p - 1) / m_p) : 0;
        if (m_nr > steps) m_nr = steps;
    endtask

    // Called #1 after an edge; the accept happens on the next edge (t=0).
    task automatic run_cmd(input int steps, input int period, input bit d, input int abort_at,
                           input bit noise, output int rises, output int end_obs,
                           output int left_fin);
        logic prev;
        int   changes;
        model_setup(steps, period, abort_at);
        cmd_valid  = 1'b1;
        cmd_steps  = 16'(steps);
        cmd_period = 16'(period);
        cmd_dir    = d;
        abort      = 1'b0;
        prev       = step;
        changes    = 0;
        rises      = 0;
        end_obs    = -1;
        left_fin   = -1;
        for (int t = 0; t <= m_end; t++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            chk("step", step, m_step(t));
            chk("busy", busy, (t < m_end) ? 1 : 0);
            chk("done", done, (t == m_end) ? 1 : 0);
            chk("cmd_ready", cmd_ready, (t < m_end) ? 0 : 1);
            chk("steps_left", steps_left, m_left(t));
            chk("dir", dir, d);
            if (step !== prev) changes++;
            if (step === 1'b1 && prev === 1'b0) rises++;
            prev = step;
            if (done === 1'b1 && end_obs < 0) end_obs = t;
            left_fin = int'(steps_left);
            abort = (abort_at == t + 1);
            if (noise && t + 1 <= m_end) begin
                cmd_valid  = 1'b1;
                cmd_dir    = ~d;
                cmd_steps  = 16'd7;
                cmd_period = 16'd3;
            end
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;
        chk("edge_changes", changes, 2 * m_nr);
    endtask

    task automatic idle_cycle();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_step", step, 0);
    endtask

    typedef struct {
        int steps;
        int period;
        bit d;
        int abort_at;
        bit noise;
        bit b2b;
        int exp_rises;
        int exp_end;
        int exp_left;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int   rises, end_obs, left_fin;
        int   steps, period, abort_at;
        bit   d, noise, b2b;
        logic stray;

        vecs[0]  = '{3, 10, 1'b1, 0,  1'b0, 1'b0, 3, 32, 0};
        vecs[1]  = '{0, 10, 1'b1, 0,  1'b0, 1'b0, 0, 0,  0};
        vecs[2]  = '{2, 2,  1'b0, 0,  1'b0, 1'b0, 2, 12, 0};
        vecs[3]  = '{5, 10, 1'b1, 14, 1'b0, 1'b0, 2, 16, 3};
        vecs[4]  = '{4, 6,  1'b0, 1,  1'b0, 1'b0, 0, 1,  4};
        vecs[5]  = '{3, 5,  1'b1, 17, 1'b0, 1'b0, 3, 17, 0};
        vecs[6]  = '{2, 8,  1'b1, 8,  1'b0, 1'b0, 1, 8,  1};
        vecs[7]  = '{1, 1,  1'b1, 0,  1'b0, 1'b0, 1, 7,  0};
        vecs[8]  = '{2, 10, 1'b0, 12, 1'b0, 1'b0, 1, 12, 1};
        vecs[9]  = '{1, 10, 1'b1, 3,  1'b0, 1'b0, 1, 6,  0};
        vecs[10] = '{2, 6,  1'b1, 0,  1'b1, 1'b1, 2, 14, 0};
        vecs[11] = '{1, 10, 1'b0, 0,  1'b0, 1'b0, 1, 12, 0};

        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_steps_left", steps_left, 0);
        chk("rst_ready", cmd_ready, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a pulse.
        cmd_valid  = 1'b1;
        cmd_steps  = 16'd3;
        cmd_period = 16'd10;
        cmd_dir    = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_step_high", step, 1);
        rst = 1'b0;
        #1;
        chk("arst_step", step, 0);
        chk("arst_dir", dir, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_steps_left", steps_left, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", cmd_ready, 1);
        stray = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (step !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        chk("post_rst_quiet", stray, 0);

        for (int i = 0; i < 12; i++) begin
            run_cmd(vecs[i].steps, vecs[i].period, vecs[i].d, vecs[i].abort_at,
                    vecs[i].noise, rises, end_obs, left_fin);
            chk($sformatf("vec%0d_rises", i), rises, vecs[i].exp_rises);
            chk($sformatf("vec%0d_end", i), end_obs, vecs[i].exp_end);
            chk($sformatf("vec%0d_left", i), left_fin, vecs[i].exp_left);
            if (!vecs[i].b2b) idle_cycle();
        end

        for (int i = 0; i < 40; i++) begin
            steps    = int'($urandom_range(0, 4));
            period   = int'($urandom_range(0, 14));
            d        = 1'($urandom % 2);
            noise    = 1'($urandom % 2);
            b2b      = 1'($urandom % 2);
            abort_at = ($urandom % 3 == 0) ?
                       int'($urandom_range(1, DS + steps * peff(period) + 1)) : 0;
            run_cmd(steps, period, d, abort_at, noise, rises, end_obs, left_fin);
            chk("rnd_rises", rises, m_nr);
            chk("rnd_end", end_obs, m_end);
            if (!b2b) idle_cycle();
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
